snake_ram_arbiter: RTL and testbench

SNAKE_RAM_ARBITER -- requirements
Module: snake_ram_arbiter

---
 rtl/snake_pkg.sv | 17 +
 rtl/snake_prio_sel.sv | 27 ++
 rtl/snake_ram_arbiter.sv | 130 +++++++++++++
 tb/tb_snake_ram_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake-body RAM arbiter and its priority selector.
package snake_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam int REQ_VGA  = 0;
    localparam int REQ_MOV  = 1;
    localparam int REQ_FOOD = 2;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 16;

endpackage

// File: rtl/snake_prio_sel.sv
// One-hot winner select: VGA first, then movement, then food; a starved food request
// overtakes movement unless movement currently holds a lock.
module snake_prio_sel
    import snake_pkg::*;
(
    input  logic [2:0] i_pending,
    input  logic       i_starve,
    input  logic       i_lock,
    output logic [2:0] o_winner
);

    logic w_food_overtakes;

    assign w_food_overtakes = i_pending[REQ_FOOD] & i_starve & ~i_lock;

    always_comb begin
        o_winner = 3'b000;
        if (i_pending[REQ_VGA]) begin
            o_winner[REQ_VGA] = 1'b1;
        end else if (i_pending[REQ_MOV] && !w_food_overtakes) begin
            o_winner[REQ_MOV] = 1'b1;
        end else if (i_pending[REQ_FOOD]) begin
            o_winner[REQ_FOOD] = 1'b1;
        end
    end

endmodule

// File: rtl/snake_ram_arbiter.sv
// Arbitrates the single-port snake-body RAM between VGA, movement and food requesters.
// Requests are sampled every edge; a requester still high on the edge after its ack presents a new request.
module snake_ram_arbiter
    import snake_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = 8,
    parameter int LOCK_MAX   = 16
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              v_req,
    input  logic [ADDR_W-1:0] v_addr,
    input  logic              m_req,
    input  logic              m_we,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_wdata,
    input  logic              m_lock,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic [2:0]        ack,
    output logic [2:0]        rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr_en,
    output logic              ram_rd_en,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    localparam int LCNT_W = $clog2(LOCK_MAX + 1);

    state_t            r_state;
    logic              r_armed;
    logic [3:0]        r_starve;
    logic [LCNT_W-1:0] r_lock_cnt;
    logic [2:0]        r_ack;
    logic [2:0]        r_rvalid;
    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_ram_wr_en;
    logic              r_ram_rd_en;
    logic [DATA_W-1:0] r_ram_wdata;

    logic [2:0]        w_pending;
    logic [2:0]        w_winner;
    logic              w_starved;
    logic              w_locked;
    logic              w_mov_write;
    logic              w_lock_next;
    logic              w_hold_lock;
    logic [LCNT_W-1:0] w_next_cnt;

    assign w_pending   = r_armed ? {f_req, m_req, v_req} : 3'b000;
    assign w_starved   = (r_starve >= 4'(STARVE_MAX));
    assign w_locked    = (r_state == ST_LOCKED);
    assign w_mov_write = w_winner[REQ_MOV] & m_we;
    assign w_next_cnt  = w_locked ? r_lock_cnt + LCNT_W'(1) : LCNT_W'(1);
    assign w_lock_next = w_winner[REQ_MOV] & m_lock & (w_next_cnt < LCNT_W'(LOCK_MAX));
    // A VGA read may slip in during a lock without breaking it.
    assign w_hold_lock = w_locked & w_winner[REQ_VGA] & m_req & m_lock;

    snake_prio_sel u_prio_sel (
        .i_pending (w_pending),
        .i_starve  (w_starved),
        .i_lock    (w_locked),
        .o_winner  (w_winner)
    );

    // The first clock after reset only arms the sampler, so the first grant lands two cycles after release.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_armed     <= 1'b0;
            r_starve    <= 4'd0;
            r_lock_cnt  <= '0;
            r_ack       <= 3'b000;
            r_rvalid    <= 3'b000;
            r_ram_addr  <= '0;
            r_ram_wr_en <= 1'b0;
            r_ram_rd_en <= 1'b0;
            r_ram_wdata <= '0;
        end else begin
            r_armed     <= 1'b1;
            r_ack       <= w_winner;
            r_ram_wr_en <= w_mov_write;
            r_ram_rd_en <= (|w_winner) & ~w_mov_write;
            r_rvalid    <= r_ram_rd_en ? r_ack : 3'b000;

            if (w_winner[REQ_VGA]) begin
                r_ram_addr <= v_addr;
            end else if (w_winner[REQ_MOV]) begin
                r_ram_addr <= m_addr;
            end else if (w_winner[REQ_FOOD]) begin
                r_ram_addr <= f_addr;
            end

            if (w_mov_write) begin
                r_ram_wdata <= m_wdata;
            end

            if (!w_pending[REQ_FOOD] || w_winner[REQ_FOOD]) begin
                r_starve <= 4'd0;
            end else if (!w_starved) begin
                r_starve <= r_starve + 4'd1;
            end

            if (w_lock_next) begin
                r_state    <= ST_LOCKED;
                r_lock_cnt <= w_next_cnt;
            end else if (w_hold_lock) begin
                r_state    <= ST_LOCKED;
            end else begin
                r_lock_cnt <= '0;
                r_state    <= (|w_winner) ? ST_GRANT : ST_IDLE;
            end
        end
    end

    assign ack       = r_ack;
    assign rvalid    = r_rvalid;
    assign rdata     = (|r_rvalid) ? ram_rdata : '0;
    assign ram_addr  = r_ram_addr;
    assign ram_wr_en = r_ram_wr_en;
    assign ram_rd_en = r_ram_rd_en;
    assign ram_wdata = r_ram_wdata;
    assign busy      = w_locked | r_ram_rd_en;

endmodule

// File: tb/tb_snake_ram_arbiter.sv
// Bench for snake_ram_arbiter: a RAM behind the arbiter, a cycle-level model of the
// arbitration rules checked every cycle, and directed scenarios with literal expectations.
module tb_snake_ram_arbiter;

    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 16;
    localparam int STARVE_MAX = 8;
    localparam int LOCK_MAX   = 16;
    localparam int DEPTH      = 1 << ADDR_W;

    logic              clock;
    logic              reset;
    logic              vReq;
    logic [ADDR_W-1:0] vAddr;
    logic              mReq;
    logic              mWe;
    logic [ADDR_W-1:0] mAddr;
    logic [DATA_W-1:0] mWdata;
    logic              mLock;
    logic              fReq;
    logic [ADDR_W-1:0] fAddr;
    logic [2:0]        ack;
    logic [2:0]        rvalid;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] ramAddr;
    logic              ramWrEn;
    logic              ramRdEn;
    logic [DATA_W-1:0] ramWdata;
    logic [DATA_W-1:0] ramRdata;
    logic              busy;

    int checkCount = 0;
    int errorCount = 0;

    logic [DATA_W-1:0] ramMem [DEPTH];
    logic [DATA_W-1:0] mdlMem [DEPTH];

    bit                mdlArmed;
    bit                mdlLockOn;
    int                mdlStarve;
    int                mdlLockGrants;
    int                mdlWinner;
    logic [DATA_W-1:0] mdlReadData;
    logic [2:0]        expAck;
    logic [2:0]        expRvalid;
    logic [DATA_W-1:0] expRdata;
    logic [ADDR_W-1:0] expAddr;
    logic [DATA_W-1:0] expWdata;
    logic              expWr;
    logic              expRd;
    logic              expBusy;

    int  movCount;
    int  foodAt;
    int  vgaLatency;
    int  injectCycle;
    bit  gotFood;
    bit  vgaSent;
    bit  doneMov;

    snake_ram_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (STARVE_MAX),
        .LOCK_MAX   (LOCK_MAX)
    ) dut (
        .clk       (clock),
        .RST       (reset),
        .v_req     (vReq),
        .v_addr    (vAddr),
        .m_req     (mReq),
        .m_we      (mWe),
        .m_addr    (mAddr),
        .m_wdata   (mWdata),
        .m_lock    (mLock),
        .f_req     (fReq),
        .f_addr    (fAddr),
        .ack       (ack),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .ram_addr  (ramAddr),
        .ram_wr_en (ramWrEn),
        .ram_rd_en (ramRdEn),
        .ram_wdata (ramWdata),
        .ram_rdata (ramRdata),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ramMem[i] = DATA_W'(32'h1000 + i);
            mdlMem[i] = DATA_W'(32'h1000 + i);
        end
        ramRdata = '0;
    end

    always @(posedge clock) begin
        if (ramWrEn) ramMem[ramAddr] <= ramWdata;
        if (ramRdEn) ramRdata <= ramMem[ramAddr];
    end

    function automatic int pickWinner(bit v, bit m, bit f, bit starved, bit locked);
        if (v) return 0;
        if (m && f) return (starved && !locked) ? 2 : 1;
        if (m) return 1;
        if (f) return 2;
        return -1;
    endfunction

    // Model: what the outputs must be in the cycle after each edge.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mdlArmed = 1'b0; mdlLockOn = 1'b0; mdlStarve = 0; mdlLockGrants = 0; mdlWinner = -1;
            mdlReadData = '0; expAck = 3'b000; expRvalid = 3'b000; expRdata = '0;
            expAddr = '0; expWdata = '0; expWr = 1'b0; expRd = 1'b0; expBusy = 1'b0;
        end else begin
            expRvalid = expRd ? expAck : 3'b000;
            expRdata  = expRd ? mdlReadData : '0;
            mdlWinner = mdlArmed ? pickWinner(vReq, mReq, fReq, mdlStarve >= STARVE_MAX, mdlLockOn) : -1;
            case (mdlWinner)
                0:       expAck = 3'b001;
                1:       expAck = 3'b010;
                2:       expAck = 3'b100;
                default: expAck = 3'b000;
            endcase
            expWr = 1'b0;
            expRd = 1'b0;
            if (mdlWinner == 1 && mWe) begin
                expWr = 1'b1; expAddr = mAddr; expWdata = mWdata;
                mdlMem[mAddr] = mWdata;
            end else if (mdlWinner >= 0) begin
                expRd = 1'b1;
                expAddr = (mdlWinner == 0) ? vAddr : (mdlWinner == 1) ? mAddr : fAddr;
                mdlReadData = mdlMem[expAddr];
            end
            if (!(mdlArmed && fReq) || mdlWinner == 2) mdlStarve = 0;
            else mdlStarve = (mdlStarve < STARVE_MAX) ? mdlStarve + 1 : STARVE_MAX;
            if (mdlWinner == 1 && mLock) begin
                mdlLockGrants = mdlLockOn ? mdlLockGrants + 1 : 1;
                mdlLockOn = (mdlLockGrants < LOCK_MAX);
                if (!mdlLockOn) mdlLockGrants = 0;
            end else if (!(mdlLockOn && mdlWinner == 0 && mReq && mLock)) begin
                mdlLockOn = 1'b0;
                mdlLockGrants = 0;
            end
            expBusy = mdlLockOn || expRd;
            mdlArmed = 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clock) begin
        checkOutput("cyc_ack", 32'(ack), 32'(expAck));
        checkOutput("cyc_rvalid", 32'(rvalid), 32'(expRvalid));
        checkOutput("cyc_wr_en", 32'(ramWrEn), 32'(expWr));
        checkOutput("cyc_rd_en", 32'(ramRdEn), 32'(expRd));
        checkOutput("cyc_busy", 32'(busy), 32'(expBusy));
        if (expWr || expRd) checkOutput("cyc_addr", 32'(ramAddr), 32'(expAddr));
        if (expWr) checkOutput("cyc_wdata", 32'(ramWdata), 32'(expWdata));
        if (expRvalid != 3'b000) checkOutput("cyc_rdata", 32'(rdata), 32'(expRdata));
    end

    task automatic applyStimulus(input logic v, input logic [ADDR_W-1:0] va,
                                 input logic m, input logic we, input logic [ADDR_W-1:0] ma,
                                 input logic [DATA_W-1:0] wd, input logic lk,
                                 input logic f, input logic [ADDR_W-1:0] fa);
        vReq = v; vAddr = va; mReq = m; mWe = we; mAddr = ma;
        mWdata = wd; mLock = lk; fReq = f; fAddr = fa;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ack"}, 32'(ack), 32'h0);
        checkOutput({tag, "_rvalid"}, 32'(rvalid), 32'h0);
        checkOutput({tag, "_wr_en"}, 32'(ramWrEn), 32'h0);
        checkOutput({tag, "_rd_en"}, 32'(ramRdEn), 32'h0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
        checkOutput({tag, "_rdata"}, 32'(rdata), 32'h0);
        checkOutput({tag, "_addr"}, 32'(ramAddr), 32'h0);
        checkOutput({tag, "_wdata"}, 32'(ramWdata), 32'h0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, errors so far %0d", errorCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        applyStimulus(0, '0, 0, 0, '0, '0, 0, 0, '0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkAllZero("reset");
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (2) begin @(posedge clock); #1; end

        $display("[TB] single movement write");
        applyStimulus(0, '0, 1, 1, 10'd5, 16'h00A3, 0, 0, '0);
        @(posedge clock); #1;
        applyStimulus(0, '0, 0, 0, '0, '0, 0, 0, '0);
        checkOutput("wr_ack", 32'(ack), 32'h2);
        checkOutput("wr_en", 32'(ramWrEn), 32'h1);
        checkOutput("wr_addr", 32'(ramAddr), 32'd5);
        checkOutput("wr_wdata", 32'(ramWdata), 32'h00A3);
        @(posedge clock); #1;
        checkOutput("wr_no_rvalid", 32'(rvalid), 32'h0);

        $display("[TB] VGA and movement together");
        applyStimulus(1, 10'd5, 1, 0, 10'd7, '0, 0, 0, '0);
        @(posedge clock); #1;
        vReq = 1'b0;
        checkOutput("both_ack_vga", 32'(ack), 32'h1);
        checkOutput("both_rd_addr", 32'(ramAddr), 32'd5);
        @(posedge clock); #1;
        mReq = 1'b0;
        checkOutput("both_ack_mov", 32'(ack), 32'h2);
        checkOutput("both_rvalid_vga", 32'(rvalid), 32'h1);
        checkOutput("both_rdata_vga", 32'(rdata), 32'h00A3);
        @(posedge clock); #1;
        checkOutput("both_rvalid_mov", 32'(rvalid), 32'h2);
        checkOutput("both_rdata_mov", 32'(rdata), 32'h1007);

        $display("[TB] food starvation");
        applyStimulus(0, '0, 1, 0, 10'd100, '0, 0, 1, 10'd200);
        movCount = 0; gotFood = 1'b0;
        for (int c = 0; c < 40 && !gotFood; c++) begin
            @(posedge clock); #1;
            if (ack == 3'b010) begin
                movCount++;
                mAddr = ADDR_W'(100 + movCount);
            end else if (ack == 3'b100) begin
                gotFood = 1'b1; fReq = 1'b0; mReq = 1'b0;
            end
        end
        checkOutput("starve_food_seen", 32'(gotFood), 32'h1);
        checkOutput("starve_mov_grants", 32'(movCount), 32'd8);
        repeat (2) begin @(posedge clock); #1; end

        $display("[TB] movement lock with food pending and a VGA interruption");
        applyStimulus(0, '0, 1, 1, 10'd32, 16'hB000, 1, 1, 10'd40);
        movCount = 0; foodAt = -1; vgaSent = 1'b0; vgaLatency = -1; injectCycle = 0; doneMov = 1'b0;
        for (int c = 0; c < 80 && !doneMov; c++) begin
            @(posedge clock); #1;
            if (ack == 3'b010) begin
                movCount++;
                mAddr  = ADDR_W'(32 + movCount);
                mWdata = DATA_W'(32'hB000 + movCount);
                if (movCount == 20) begin mReq = 1'b0; mLock = 1'b0; doneMov = 1'b1; end
            end else if (ack == 3'b100 && foodAt < 0) begin
                foodAt = movCount; fReq = 1'b0;
            end else if (ack == 3'b001 && vgaSent && vgaLatency < 0) begin
                vgaLatency = c - injectCycle; vReq = 1'b0;
            end
            if (movCount == 5 && !vgaSent) begin
                vReq = 1'b1; vAddr = 10'd5; vgaSent = 1'b1; injectCycle = c;
            end
        end
        checkOutput("lock_all_mov_done", 32'(doneMov), 32'h1);
        checkOutput("lock_mov_before_food", 32'(foodAt), 32'd16);
        checkOutput("lock_vga_latency_ok", 32'(vgaLatency >= 1 && vgaLatency <= 2), 32'h1);
        repeat (3) begin @(posedge clock); #1; end

        $display("[TB] reset during an outstanding read");
        applyStimulus(1, 10'd3, 0, 0, '0, '0, 0, 0, '0);
        @(posedge clock); #1;
        vReq = 1'b0;
        checkOutput("rst_pre_ack", 32'(ack), 32'h1);
        checkOutput("rst_pre_rd_en", 32'(ramRdEn), 32'h1);
        #2 reset = 1'b1;
        #1 checkAllZero("rst_now");
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("rst_hold_rvalid", 32'(rvalid), 32'h0);
        @(posedge clock); #1;
        reset = 1'b0;
        vReq = 1'b1; vAddr = 10'd9;
        @(posedge clock); #1;
        checkOutput("rel_ack_cycle1", 32'(ack), 32'h0);
        @(posedge clock); #1;
        vReq = 1'b0;
        checkOutput("rel_ack_cycle2", 32'(ack), 32'h1);
        @(posedge clock); #1;
        checkOutput("rel_rvalid", 32'(rvalid), 32'h1);
        checkOutput("rel_rdata", 32'(rdata), 32'h1009);

        repeat (4) @(posedge clock);
        @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
